// File: rtl/vram_arbiter.sv
// Video RAM arbiter: display fetches own their ph0 slot; host requests queue in order
// and take any free RAM cycle. Read data returns through a two-stage tag pipeline.
module vram_arbiter #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 16,
  parameter int QDEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ph0,
  input  logic              de,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic              vid_valid,
  output logic [DATA_W-1:0] vid_data,
  input  logic              host_valid,
  output logic              host_ready,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  output logic              ram_cs,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);
  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(QDEPTH);

  logic              q_we_r    [QDEPTH];
  logic [ADDR_W-1:0] q_addr_r  [QDEPTH];
  logic [DATA_W-1:0] q_wdata_r [QDEPTH];
  logic [PW-1:0]     head_r, tail_r;
  logic [CW-1:0]     count_r;
  logic [ADDR_W-1:0] addr_hold_r;
  logic [DATA_W-1:0] wdata_hold_r;
  logic              s1_disp_r, s1_host_rd_r;

  logic disp_slot_s, full_s, empty_s, push_s, pop_s, head_we_s;

  assign disp_slot_s = ph0 & de;
  assign full_s      = (count_r == FULL_CNT);
  assign empty_s     = (count_r == {CW{1'b0}});
  // Ready looks only at the registered count, so a same-cycle pop never raises it.
  assign host_ready  = rst_n & ~full_s;
  assign push_s      = host_valid & host_ready;
  assign pop_s       = rst_n & ~disp_slot_s & ~empty_s;
  assign head_we_s   = q_we_r[head_r];

  // Queue entry storage, written at the tail on accept.
  always_ff @(posedge clk) begin
    if (push_s) begin
      q_we_r[tail_r]    <= host_we;
      q_addr_r[tail_r]  <= host_addr;
      q_wdata_r[tail_r] <= host_wdata;
    end
  end

  // Queue pointers and occupancy count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_r  <= {PW{1'b0}};
      tail_r  <= {PW{1'b0}};
      count_r <= {CW{1'b0}};
    end else begin
      if (push_s) tail_r <= tail_r + PW'(1);
      if (pop_s)  head_r <= head_r + PW'(1);
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // RAM port mux: display slot first, then queue head, else idle with held bus.
  always_comb begin
    ram_cs    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = addr_hold_r;
    ram_wdata = wdata_hold_r;
    if (disp_slot_s) begin
      ram_cs   = 1'b1;
      ram_addr = vid_addr;
    end else if (pop_s) begin
      ram_cs    = 1'b1;
      ram_we    = head_we_s;
      ram_addr  = q_addr_r[head_r];
      ram_wdata = q_wdata_r[head_r];
    end else begin
      ram_cs = 1'b0;
    end
  end

  // Remember the last driven address/data so idle cycles keep the bus stable.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_hold_r  <= {ADDR_W{1'b0}};
      wdata_hold_r <= {DATA_W{1'b0}};
    end else begin
      addr_hold_r  <= ram_addr;
      wdata_hold_r <= ram_wdata;
    end
  end

  // Return path: stage 1 tags the access, stage 2 captures RAM data into the right sink.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_disp_r    <= 1'b0;
      s1_host_rd_r <= 1'b0;
      vid_valid    <= 1'b0;
      host_rvalid  <= 1'b0;
      vid_data     <= {DATA_W{1'b0}};
      host_rdata   <= {DATA_W{1'b0}};
    end else begin
      s1_disp_r    <= disp_slot_s;
      s1_host_rd_r <= pop_s & ~head_we_s;
      vid_valid    <= s1_disp_r;
      host_rvalid  <= s1_host_rd_r;
      if (s1_disp_r)    vid_data   <= ram_rdata;
      if (s1_host_rd_r) host_rdata <= ram_rdata;
    end
  end
endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a behavioural single-port RAM (one-cycle read latency).
module tb_vram_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        ph0, de;
  logic [12:0] vid_addr;
  logic        vid_valid;
  logic [15:0] vid_data;
  logic        host_valid, host_ready, host_we;
  logic [12:0] host_addr;
  logic [15:0] host_wdata;
  logic        host_rvalid;
  logic [15:0] host_rdata;
  logic        ram_cs, ram_we;
  logic [12:0] ram_addr;
  logic [15:0] ram_wdata;
  logic [15:0] ram_rdata;

  logic [15:0] mem [8192];
  int checks = 0;
  int fails  = 0;

  vram_arbiter #(.ADDR_W(13), .DATA_W(16), .QDEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .ph0(ph0), .de(de), .vid_addr(vid_addr),
    .vid_valid(vid_valid), .vid_data(vid_data),
    .host_valid(host_valid), .host_ready(host_ready), .host_we(host_we),
    .host_addr(host_addr), .host_wdata(host_wdata),
    .host_rvalid(host_rvalid), .host_rdata(host_rdata),
    .ram_cs(ram_cs), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_cs) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata <= mem[ram_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      fails++;
      $display("FAIL %s: observed %h expected %h", tag, got, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic next;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; ph0 = 1'b0; de = 1'b0; vid_addr = 13'h0000;
    host_valid = 1'b1; host_we = 1'b1; host_addr = 13'h0005; host_wdata = 16'hBEEF;
    ram_rdata = 16'h0000;
    for (int i = 0; i < 8192; i++) mem[i] = 16'(i) ^ 16'hA5A5;

    // Reset held three cycles with a pending host request.
    for (int i = 0; i < 3; i++) begin
      next; #1;
      chk("rst_ready", host_ready, 1'b0);
      chk("rst_vvalid", vid_valid, 1'b0);
      chk("rst_hrvalid", host_rvalid, 1'b0);
      chk("rst_ram_we", ram_we, 1'b0);
    end
    chk("rst_vid_data", vid_data, 16'h0000);
    chk("rst_host_rdata", host_rdata, 16'h0000);
    next; rst_n = 1'b1; host_valid = 1'b0; #1;
    chk("rel_ready", host_ready, 1'b1);
    chk("rel_ram_cs", ram_cs, 1'b0);

    // Display fetches every 4 cycles.
    de = 1'b1;
    for (int k = 0; k < 3; k++) begin
      next; ph0 = 1'b1; vid_addr = 13'(k); #1;
      chk("disp_cs", ram_cs, 1'b1);
      chk("disp_we", ram_we, 1'b0);
      chk("disp_addr", ram_addr, 13'(k));
      next; ph0 = 1'b0; #1;
      chk("disp_vv_early", vid_valid, 1'b0);
      next; #1;
      chk("disp_vv", vid_valid, 1'b1);
      chk("disp_data", vid_data, 16'(k) ^ 16'hA5A5);
      next; #1;
      chk("disp_vv_pulse", vid_valid, 1'b0);
    end

    // Host write 0x1234 to 0x1FFF, then read it back.
    next; host_valid = 1'b1; host_we = 1'b1; host_addr = 13'h1FFF; host_wdata = 16'h1234; #1;
    chk("hw_ready", host_ready, 1'b1);
    chk("hw_cs_idle", ram_cs, 1'b0);
    next; host_we = 1'b0; #1;
    chk("hw_we", ram_we, 1'b1);
    chk("hw_addr", ram_addr, 13'h1FFF);
    chk("hw_wdata", ram_wdata, 16'h1234);
    next; host_valid = 1'b0; #1;
    chk("hr_cs", ram_cs, 1'b1);
    chk("hr_we", ram_we, 1'b0);
    chk("hr_addr", ram_addr, 13'h1FFF);
    next; #1;
    chk("idle_cs", ram_cs, 1'b0);
    chk("idle_addr_hold", ram_addr, 13'h1FFF);
    chk("hr_rv_early", host_rvalid, 1'b0);
    next; #1;
    chk("hr_rvalid", host_rvalid, 1'b1);
    chk("hr_rdata", host_rdata, 16'h1234);
    next; #1;
    chk("hr_rv_pulse", host_rvalid, 1'b0);
    chk("hr_rdata_hold", host_rdata, 16'h1234);

    // Collision: host read accepted the cycle before a display slot.
    next; host_valid = 1'b1; host_we = 1'b0; host_addr = 13'h0010; #1;
    next; host_valid = 1'b0; ph0 = 1'b1; vid_addr = 13'h0020; #1;
    chk("col_disp_addr", ram_addr, 13'h0020);
    chk("col_disp_we", ram_we, 1'b0);
    next; ph0 = 1'b0; #1;
    chk("col_host_cs", ram_cs, 1'b1);
    chk("col_host_addr", ram_addr, 13'h0010);
    next; #1;
    chk("col_vv", vid_valid, 1'b1);
    chk("col_vdata", vid_data, 16'hA585);
    chk("col_hrv_early", host_rvalid, 1'b0);
    next; #1;
    chk("col_hrv", host_rvalid, 1'b1);
    chk("col_hdata", host_rdata, 16'hA5B5);
    chk("col_vv_pulse", vid_valid, 1'b0);

    // ph0 with de=0 leaves the slot to the host and makes no display data.
    next; host_valid = 1'b1; host_we = 1'b0; host_addr = 13'h0003; #1;
    next; host_valid = 1'b0; ph0 = 1'b1; de = 1'b0; vid_addr = 13'h0007; #1;
    chk("nde_cs", ram_cs, 1'b1);
    chk("nde_addr", ram_addr, 13'h0003);
    next; ph0 = 1'b0; de = 1'b1; #1;
    next; #1;
    chk("nde_vv", vid_valid, 1'b0);
    chk("nde_hrv", host_rvalid, 1'b1);
    chk("nde_hdata", host_rdata, 16'hA5A6);

    // Backpressure: four writes while ph0 stays high for three cycles.
    next; ph0 = 1'b1; vid_addr = 13'h0040;
    host_valid = 1'b1; host_we = 1'b1; host_addr = 13'h0100; host_wdata = 16'hD000; #1;
    chk("bp0_ready", host_ready, 1'b1);
    chk("bp0_we", ram_we, 1'b0);
    next; host_addr = 13'h0101; host_wdata = 16'hD001; #1;
    chk("bp1_ready", host_ready, 1'b1);
    chk("bp1_we", ram_we, 1'b0);
    next; host_addr = 13'h0102; host_wdata = 16'hD002; #1;
    chk("bp2_ready", host_ready, 1'b0);
    chk("bp2_we", ram_we, 1'b0);
    next; ph0 = 1'b0; #1;
    chk("bp3_ready", host_ready, 1'b0);
    chk("bp3_we", ram_we, 1'b1);
    chk("bp3_addr", ram_addr, 13'h0100);
    chk("bp3_wdata", ram_wdata, 16'hD000);
    next; #1;
    chk("bp4_ready", host_ready, 1'b1);
    chk("bp4_we", ram_we, 1'b1);
    chk("bp4_addr", ram_addr, 13'h0101);
    chk("bp4_wdata", ram_wdata, 16'hD001);
    next; host_addr = 13'h0103; host_wdata = 16'hD003; #1;
    chk("bp5_ready", host_ready, 1'b1);
    chk("bp5_we", ram_we, 1'b1);
    chk("bp5_addr", ram_addr, 13'h0102);
    chk("bp5_wdata", ram_wdata, 16'hD002);
    next; host_valid = 1'b0; #1;
    chk("bp6_we", ram_we, 1'b1);
    chk("bp6_addr", ram_addr, 13'h0103);
    chk("bp6_wdata", ram_wdata, 16'hD003);
    next; #1;
    chk("bp7_cs", ram_cs, 1'b0);
    chk("bp_mem0", mem[13'h0100], 16'hD000);
    chk("bp_mem1", mem[13'h0101], 16'hD001);
    chk("bp_mem2", mem[13'h0102], 16'hD002);
    chk("bp_mem3", mem[13'h0103], 16'hD003);

    // Reset right after a host read issues, with a write still queued.
    next; host_valid = 1'b1; host_we = 1'b0; host_addr = 13'h0005; #1;
    next; host_we = 1'b1; host_addr = 13'h0006; host_wdata = 16'h7777; #1;
    chk("mr_issue_cs", ram_cs, 1'b1);
    chk("mr_issue_we", ram_we, 1'b0);
    chk("mr_issue_addr", ram_addr, 13'h0005);
    next; rst_n = 1'b0; host_valid = 1'b0; #1;
    chk("mr_rst_ready", host_ready, 1'b0);
    chk("mr_rst_we", ram_we, 1'b0);
    next; rst_n = 1'b1; #1;
    chk("mr_no_rvalid", host_rvalid, 1'b0);
    chk("mr_q_empty", ram_cs, 1'b0);
    chk("mr_ready", host_ready, 1'b1);
    next; #1;
    chk("mr_no_rvalid2", host_rvalid, 1'b0);
    chk("mr_write_dropped", mem[13'h0006], 16'hA5A3);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule

// File: doc/vram_arbiter.md
# vram_arbiter

Shares the single-port video RAM between the display fetch pipeline and a host (CPU/bus) port. Display fetches always get their slot; host reads and writes go through a small in-order request queue and use every other RAM cycle. It sits between the video timing controller (address source) and the character-ROM stage (data sink), with the host bus on its second side.

## Interface
Parameters:
- ADDR_W, 13, VRAM word address width
- DATA_W, 16, VRAM word width (character + attribute)
- QDEPTH, 2, host request queue depth; power of two, ≥2

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, synchronous, active-low
- ph0  in  1  display fetch slot strobe, one-cycle pulse per character period
- de  in  1  display enable, qualified by ph0
- vid_addr  in  ADDR_W  display fetch address, valid when ph0=1
- vid_valid  out  1  display data valid pulse
- vid_data  out  DATA_W  display fetch data
- host_valid  in  1  host request valid
- host_ready  out  1  queue can accept
- host_we  in  1  1=write, 0=read
- host_addr  in  ADDR_W  host word address
- host_wdata  in  DATA_W  host write data
- host_rvalid  out  1  host read data valid pulse
- host_rdata  out  DATA_W  host read data
- ram_cs  out  1  RAM access this cycle
- ram_we  out  1  RAM write enable
- ram_addr  out  ADDR_W  RAM address
- ram_wdata  out  DATA_W  RAM write data
- ram_rdata  in  DATA_W  RAM read data, valid one cycle after a read access

## Operation
- disp_slot = ph0 & de (combinational). In a disp_slot cycle: ram_cs=1, ram_we=0, ram_addr=vid_addr; host queue not popped.
- Host queue: FIFO of {we, addr, wdata}, QDEPTH entries, registered count. Push on host_valid & host_ready. host_ready = !full, derived from registered count only; a pop in the same cycle does not raise ready.
- Issue: any cycle with disp_slot=0 and queue non-empty pops the head and drives ram_cs=1, ram_we=head.we, ram_addr=head.addr, ram_wdata=head.wdata. One host access per non-display cycle; strict FIFO order.
- ph0=1 with de=0: slot is free for host; no vid_valid generated.
- Idle (no slot, queue empty): ram_cs=0, ram_we=0; ram_addr/ram_wdata hold their last value.
- Return path: two-stage tag pipeline {disp, host_rd}. Stage 1 records the access type; stage 2 registers ram_rdata into vid_data or host_rdata and pulses the matching valid. Host writes produce no response.
- vid_data and host_rdata hold their value between valid pulses.
- Reset (rst_n=0 at an edge): queue emptied, tag pipeline cleared. A read in flight produces no rvalid. All registered outputs go to 0. host_ready=0 while in reset and 1 from the first cycle after release. ram_* follow the combinational rules, except host issue is blocked in reset.

## Timing
- Display: access in cycle T; vid_valid=1 with data in T+2. Fixed latency, no jitter.
- Host read: accepted in cycle A, issued at earliest A+1, in the first later non-display cycle. host_rvalid fires 2 cycles after issue.
- Host write: committed in the RAM at the issue cycle.
- Worst-case queue wait per entry is 1 cycle per consecutive disp_slot cycle. With ph0 spaced ≥2 cycles, there is no starvation.
- Queue full at cycle T with a pop at T: host_ready=1 at T+1.

## Test plan
- Reset: hold rst_n=0 for 3 cycles with host_valid=1 -> host_ready=0, all valids 0, no ram_we; after release host_ready=1 next cycle.
- Display only: ph0 every 4 cycles, de=1, vid_addr=0x0000,0x0001,...; RAM model preloaded with data = addr^0xA5A5 -> vid_valid 2 cycles after each ph0, with data 0xA5A5, 0xA5A4, ...
- Host write then read: write 0x1234 to 0x1FFF, then read 0x1FFF -> ram_we in one non-slot cycle; host_rvalid later with host_rdata=0x1234.
- Collision: host request accepted the cycle before ph0&de -> display access in the slot cycle, host access in the next cycle; order and data correct.
- Backpressure: 4 back-to-back writes while de=1 and ph0 is held high for 3 cycles -> host_ready drops after 2 accepts; all 4 writes land in order; no lost or duplicated ram_we.
- Reset mid-read: host read issued, rst_n=0 in the next cycle -> no host_rvalid; queue empty after reset.
